mod_store_buffer: RTL and testbench

// - Store buffer between the MEM-stage load/store control and mod_data_mem port 1.
// - Absorbs stores into a FIFO and drains them to data memory when the port is free.
// - Loads own the memory port and are forwarded from the youngest matching buffered store.
// - Provides a flush handshake so the testbench or halt logic can empty the buffer before a memory dump.

---
 rtl/mod_store_buffer_pkg.sv | 25 ++
 rtl/mod_sb_fwd_match.sv | 43 ++++
 rtl/mod_store_buffer.sv | 147 ++++++++++++++
 tb/tb_mod_store_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : mod_store_buffer_pkg
// Brief  : Shared constants, FSM encoding and helpers for the store buffer.
// Rev    : 1.0
// ============================================================================
package mod_store_buffer_pkg;

  localparam int SB_DEPTH        = 4;
  localparam int SB_STARVE_LIMIT = 8;
  localparam int WORD_W          = 32;
  localparam int ADDR_W          = 32;

  typedef enum logic [0:0] {
    SB_RUN   = 1'b0,
    SB_FLUSH = 1'b1
  } sb_state_e;

  // Pointer width for a power-of-two entry count.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_sb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module : mod_sb_fwd_match
// Brief  : Youngest-first address match over the resident store entries.
// Rev    : 1.0
// ============================================================================
module mod_sb_fwd_match
  import mod_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = ADDR_W,
  parameter int DW    = WORD_W
) (
  input  logic [ptr_w(DEPTH)-1:0]   head,
  input  logic [ptr_w(DEPTH):0]     count,
  input  logic [AW-1:0]             key,
  input  logic [DEPTH-1:0][AW-1:0]  ent_addr,
  input  logic [DEPTH-1:0][DW-1:0]  ent_data,
  output logic                      hit,
  output logic [DW-1:0]             data
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] slot;

  // Walk oldest to youngest so a later (younger) match overrides an older one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if ((CW'(i) < count) && (ent_addr[slot] == key)) begin
        hit  = 1'b1;
        data = ent_data[slot];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_store_buffer.sv
`default_nettype none
// ============================================================================
// Module : mod_store_buffer
// Brief  : Store FIFO with load forwarding, starvation-bounded drain and flush.
// Rev    : 1.0
// ============================================================================
module mod_store_buffer
  import mod_store_buffer_pkg::*;
#(
  parameter int DEPTH        = SB_DEPTH,
  parameter int STARVE_LIMIT = SB_STARVE_LIMIT,
  parameter int AW           = ADDR_W,
  parameter int DW           = WORD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          ld_stall,
  input  logic          flush_req,
  output logic          flush_done,
  output logic          empty,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [SW-1:0]            starve_q, starve_d;
  sb_state_e                state_q, state_d;
  logic                     flush_done_q, flush_done_d;
  logic [DEPTH-1:0][AW-1:0] ent_addr_q, ent_addr_d;
  logic [DEPTH-1:0][DW-1:0] ent_data_q, ent_data_d;

  logic          enq, drain, forced, ld_grant, st_hit, fwd_hit;
  logic [DW-1:0] fwd_data;

  assign st_ready   = (count_q < CW'(DEPTH)) && (state_q == SB_RUN);
  assign enq        = st_valid && st_ready;
  assign forced     = (starve_q == SW'(STARVE_LIMIT)) ||
                      ((state_q == SB_FLUSH) && (count_q != '0));
  assign drain      = (count_q != '0) && (forced || !ld_valid);
  assign ld_grant   = ld_valid && !drain && (state_q == SB_RUN);
  assign ld_stall   = ld_valid && !ld_grant;
  assign empty      = (count_q == '0);
  assign flush_done = flush_done_q;

  mod_sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .head     (head_q),
    .count    (count_q),
    .key      (ld_addr),
    .ent_addr (ent_addr_q),
    .ent_data (ent_data_q),
    .hit      (fwd_hit),
    .data     (fwd_data)
  );

  // The store accepted this cycle is younger than anything resident.
  assign st_hit  = enq && (st_addr == ld_addr);
  assign ld_data = st_hit ? st_data : (fwd_hit ? fwd_data : mem_rdata);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (drain) begin
      mem_write = 1'b1;
      mem_addr  = ent_addr_q[head_q];
      mem_wdata = ent_data_q[head_q];
    end else if (ld_grant) begin
      mem_read = 1'b1;
      mem_addr = ld_addr;
    end
  end

  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    if (enq) begin
      ent_addr_d[tail_q] = st_addr;
      ent_data_d[tail_q] = st_data;
    end
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(enq);
    count_d = count_q + CW'(enq) - CW'(drain);

    starve_d = starve_q;
    if (drain) begin
      starve_d = '0;
    end else if ((count_q == CW'(DEPTH)) && ld_valid &&
                 (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end

    state_d      = state_q;
    flush_done_d = 1'b0;
    if (state_q == SB_RUN) begin
      if (flush_req) state_d = SB_FLUSH;
    end else if (count_d == '0) begin
      state_d      = SB_RUN;
      flush_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      state_q      <= SB_RUN;
      flush_done_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Entry payloads carry no reset; occupancy comes from count_q.
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_store_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_mod_store_buffer
// Brief  : Self-checking bench: vector table, directed corners, random vs model.
// Rev    : 1.0
// ============================================================================
module tb_mod_store_buffer;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk, reset, st_valid, ld_valid, flush_req, mem_clr;
  logic [31:0] st_addr, st_data, ld_addr, mem_rdata;
  logic        st_ready, ld_stall, flush_done, empty, mem_write, mem_read;
  logic [31:0] ld_data, mem_addr, mem_wdata;
  logic [31:0] dmem [16];

  int n_cmp = 0;
  int n_err = 0;

  mod_store_buffer #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_ready(st_ready), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
    .flush_req(flush_req), .flush_done(flush_done), .empty(empty),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side data memory on the port.
  assign mem_rdata = dmem[mem_addr[3:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'hD000 + i;
    end else if (mem_write) begin
      dmem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                     input logic lv, input logic [31:0] la, input logic fr);
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; flush_req = fr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_clr = 1'b1;
    st_valid = 0; ld_valid = 0; flush_req = 0;
    st_addr = 0; st_data = 0; ld_addr = 0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_flush_done", flush_done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0;
  endtask

  // ---------------- reference model (queue + memory image) ----------------
  typedef struct packed { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_mem [16];
  int          m_starve;
  bit          m_flush, m_fd;

  task automatic model_init();
    mq.delete();
    m_starve = 0; m_flush = 0; m_fd = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'hD000 + i;
  endtask

  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic lv, input logic [31:0] la, input logic fr);
    bit          e_rdy, enq, forced, drn, grant, hit;
    logic [31:0] e_addr, e_ldd;
    int          n;
    ent_t        e;
    drv(sv, sa, sd, lv, la, fr);
    n      = mq.size();
    e_rdy  = (n < DEPTH) && !m_flush;
    enq    = sv && e_rdy;
    forced = (m_starve == LIMIT) || (m_flush && n != 0);
    drn    = (n != 0) && (forced || !lv);
    grant  = lv && !drn && !m_flush;
    e_addr = drn ? mq[0].a : (grant ? la : 32'h0);
    hit    = 0;
    e_ldd  = m_mem[la[3:0]];
    if (enq && sa == la) begin
      hit = 1; e_ldd = sd;
    end
    for (int i = n - 1; i >= 0; i--) begin
      if (!hit && mq[i].a == la) begin
        hit = 1; e_ldd = mq[i].d;
      end
    end
    chk("r_st_ready", st_ready, e_rdy);
    chk("r_ld_stall", ld_stall, lv && !grant);
    chk("r_mem_write", mem_write, drn);
    chk("r_mem_read", mem_read, grant);
    chk("r_mem_addr", mem_addr, e_addr);
    chk("r_empty", empty, n == 0);
    chk("r_flush_done", flush_done, m_fd);
    if (drn) chk("r_mem_wdata", mem_wdata, mq[0].d);
    if (grant) chk("r_ld_data", ld_data, e_ldd);
    m_fd = 0;
    if (drn) begin
      m_mem[mq[0].a[3:0]] = mq[0].d;
      void'(mq.pop_front());
    end
    if (enq) begin
      e.a = sa; e.d = sd;
      mq.push_back(e);
    end
    if (drn) m_starve = 0;
    else if (n == DEPTH && lv && m_starve < LIMIT) m_starve++;
    if (!m_flush) begin
      if (fr) m_flush = 1;
    end else if (mq.size() == 0) begin
      m_flush = 0; m_fd = 1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic sv; logic [31:0] sa, sd; logic lv; logic [31:0] la;
    logic e_rdy, e_stall, e_wr, e_rd; logic [31:0] e_addr, e_wdata, e_ldd; logic e_empty;
  } vec_t;
  vec_t vt [8];

  initial begin
    logic [31:0] got [$];
    int          pulses, bad_rdy, bad_stall;
    int          ld_pct;

    reset = 1'b1; mem_clr = 1'b1;
    st_valid = 0; ld_valid = 0; flush_req = 0;
    st_addr = 0; st_data = 0; ld_addr = 0;

    // Youngest-entry forwarding, same-cycle forwarding, then in-order drain.
    vt[0] = '{1, 32'h04, 32'h11, 1, 32'h0C, 1, 0, 0, 1, 32'h0C, 32'h0, 32'hD00C, 1};
    vt[1] = '{1, 32'h04, 32'h22, 1, 32'h0C, 1, 0, 0, 1, 32'h0C, 32'h0, 32'hD00C, 0};
    vt[2] = '{0, 32'h00, 32'h00, 1, 32'h04, 1, 0, 0, 1, 32'h04, 32'h0, 32'h22,   0};
    vt[3] = '{1, 32'h08, 32'h05, 1, 32'h08, 1, 0, 0, 1, 32'h08, 32'h0, 32'h05,   0};
    vt[4] = '{0, 32'h00, 32'h00, 0, 32'h00, 1, 0, 1, 0, 32'h04, 32'h11, 32'h0,   0};
    vt[5] = '{0, 32'h00, 32'h00, 0, 32'h00, 1, 0, 1, 0, 32'h04, 32'h22, 32'h0,   0};
    vt[6] = '{0, 32'h00, 32'h00, 0, 32'h00, 1, 0, 1, 0, 32'h08, 32'h05, 32'h0,   0};
    vt[7] = '{0, 32'h00, 32'h00, 0, 32'h00, 1, 0, 0, 0, 32'h00, 32'h0,  32'h0,   1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv(vt[i].sv, vt[i].sa, vt[i].sd, vt[i].lv, vt[i].la, 0);
      chk($sformatf("v%0d_st_ready", i), st_ready, vt[i].e_rdy);
      chk($sformatf("v%0d_ld_stall", i), ld_stall, vt[i].e_stall);
      chk($sformatf("v%0d_mem_write", i), mem_write, vt[i].e_wr);
      chk($sformatf("v%0d_mem_read", i), mem_read, vt[i].e_rd);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_empty", i), empty, vt[i].e_empty);
      if (vt[i].e_wr) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].e_wdata);
      if (vt[i].lv && !vt[i].e_stall) chk($sformatf("v%0d_ld_data", i), ld_data, vt[i].e_ldd);
    end

    // Asynchronous reset with three entries queued discards them.
    for (int k = 0; k < 3; k++) drv(1, 32'h40 + k, 32'h77 + k, 1, 32'h1, 0);
    @(negedge clk);
    st_valid = 0; ld_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_mem_write", mem_write, 0);
    @(negedge clk);
    reset = 1'b0;
    drv(1, 32'h10, 32'hAA, 0, 0, 0);
    chk("arst_store_ready", st_ready, 1);
    chk("arst_no_write", mem_write, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk("arst_drain_write", mem_write, 1);
    chk("arst_drain_addr", mem_addr, 32'h10);
    chk("arst_drain_data", mem_wdata, 32'hAA);

    // Starvation: fill with loads held, forced drain on the 9th full cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(1, 32'h20 + k, 32'h200 + k, 1, 32'h1, 0);
      chk($sformatf("starve_fill%0d_stall", k), ld_stall, 0);
    end
    for (int c = 1; c <= 10; c++) begin
      drv(0, 0, 0, 1, 32'h1, 0);
      chk($sformatf("starve_c%0d_stall", c), ld_stall, (c == 9) ? 1 : 0);
      chk($sformatf("starve_c%0d_st_ready", c), st_ready, (c == 10) ? 1 : 0);
      if (c == 9) begin
        chk("starve_forced_write", mem_write, 1);
        chk("starve_forced_addr", mem_addr, 32'h20);
      end
    end

    // Flush across the pointer wrap: entries sit in slots 3, 0, 1.
    do_reset();
    for (int k = 0; k < 3; k++) drv(1, 32'h50 + k, 32'h0, 0, 0, 0);
    repeat (3) drv(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drv(1, 32'h31 + k, 32'h131 + k, 1, 32'h2, 0);
    drv(0, 0, 0, 1, 32'h2, 1);
    chk("flush_req_cycle_ready", st_ready, 1);
    chk("flush_req_cycle_read", mem_read, 1);
    pulses = 0; bad_rdy = 0; bad_stall = 0;
    for (int c = 1; c <= 8; c++) begin
      drv(0, 0, 0, 1, 32'h2, (c == 1) ? 1'b1 : 1'b0);
      if (flush_done) begin
        pulses++;
        chk("flush_done_ready", st_ready, 1);
      end else if (pulses == 0) begin
        if (st_ready) bad_rdy++;
        if (!ld_stall) bad_stall++;
      end
      if (mem_write) got.push_back(mem_addr);
    end
    chk("flush_pulses", pulses, 1);
    chk("flush_ready_low", bad_rdy, 0);
    chk("flush_load_stall", bad_stall, 0);
    chk("flush_drain_cnt", got.size(), 3);
    chk("flush_order0", (got.size() > 0) ? got[0] : 32'hFFFFFFFF, 32'h31);
    chk("flush_order1", (got.size() > 1) ? got[1] : 32'hFFFFFFFF, 32'h32);
    chk("flush_order2", (got.size() > 2) ? got[2] : 32'hFFFFFFFF, 32'h33);

    // Randomised traffic against the queue model, then flush and compare memory.
    do_reset();
    model_init();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ld_pct = ((cyc / 200) % 2 == 1) ? 95 : 40;
      step($urandom_range(0, 99) < 70, 32'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 99) < ld_pct, 32'($urandom_range(0, 15)),
           $urandom_range(0, 63) == 0);
    end
    step(0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 20; c++) step(0, 0, 0, 0, 0, 0);
    chk("final_model_empty", mq.size(), 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) chk($sformatf("mem_image[%0d]", i), dmem[i], m_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
